// File: rtl/bird_motion.sv
// Vertical-motion engine for the bird: gravity on a divided tick, timed lift after a flap, floor impact.
// Optional: define BIRD_CEILING_CRASH_EN to make a rising tick at the top row a crash instead of a clamp.
module bird_motion #(
    parameter int ROWS       = 16,
    parameter int TICK_DIV   = 25000000,
    parameter int RISE_TICKS = 2,
    parameter int START_ROW  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      flap,
    output logic [$clog2(ROWS)-1:0]   bird_row,
    output logic [ROWS-1:0]           bird_onehot,
    output logic                      crashed,
    output logic                      tick
);

    localparam int ROW_W  = $clog2(ROWS);
    localparam int CNT_W  = $clog2(TICK_DIV);
    localparam int RISE_W = $clog2(RISE_TICKS + 1);

    localparam logic [ROW_W-1:0]  ROW_START = ROW_W'(START_ROW);
    localparam logic [ROW_W-1:0]  ROW_TOP   = ROW_W'(ROWS - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [RISE_W-1:0] RISE_LOAD = RISE_W'(RISE_TICKS);

    typedef enum logic [1:0] {IDLE, FALL, RISE, CRASH} state_t;

    state_t             state_q, state_d;
    logic [ROW_W-1:0]   row_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RISE_W-1:0]  rise_q, rise_d;
    logic               tick_d;
    logic               tick_due;

    assign tick_due = (cnt_q == CNT_LAST);

    always_comb begin
        // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latch).
        state_d = state_q;
        row_d   = bird_row;
        cnt_d   = cnt_q;
        rise_d  = rise_q;
        tick_d  = 1'b0;

        if (!enable) begin
            state_d = IDLE;
            row_d   = ROW_START;
            cnt_d   = '0;
            rise_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = FALL;
                    row_d   = ROW_START;
                    cnt_d   = '0;
                    rise_d  = '0;
                end
                FALL, RISE: begin
                    if (flap) begin
                        // A flap restarts the tick period, so a coincident tick neither moves nor pulses.
                        state_d = RISE;
                        rise_d  = RISE_LOAD;
                        cnt_d   = '0;
                    end else if (tick_due) begin
                        cnt_d  = '0;
                        tick_d = 1'b1;
                        if (state_q == FALL) begin
                            if (bird_row == '0) begin
                                state_d = CRASH;
                            end else begin
                                row_d = bird_row - ROW_W'(1);
                            end
                        end else begin
`ifdef BIRD_CEILING_CRASH_EN
                            if (bird_row == ROW_TOP) begin
                                state_d = CRASH;
                                rise_d  = '0;
                            end else begin
                                row_d  = bird_row + ROW_W'(1);
                                rise_d = rise_q - RISE_W'(1);
                                if (rise_q == RISE_W'(1)) state_d = FALL;
                            end
`else
                            if (bird_row != ROW_TOP) row_d = bird_row + ROW_W'(1);
                            rise_d = rise_q - RISE_W'(1);
                            if (rise_q == RISE_W'(1)) state_d = FALL;
`endif
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                CRASH: begin
                    cnt_d  = '0;
                    rise_d = '0;
                end
                default: begin
                    state_d = IDLE;
                    row_d   = ROW_START;
                    cnt_d   = '0;
                    rise_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            bird_row    <= ROW_START;
            bird_onehot <= ROWS'(1) << ROW_START;
            crashed     <= 1'b0;
            tick        <= 1'b0;
            cnt_q       <= '0;
            rise_q      <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values computed above.
            state_q     <= state_d;
            bird_row    <= row_d;
            bird_onehot <= ROWS'(1) << row_d;
            crashed     <= (state_d == CRASH);
            tick        <= tick_d;
            cnt_q       <= cnt_d;
            rise_q      <= rise_d;
        end
    end

endmodule

// File: tb/tb_bird_motion.sv
// Self-checking bench for bird_motion: directed vector table, async reset checks, and random
// stimulus compared against a tick-level behavioural model.
module tb_bird_motion;

    localparam int ROWS       = 16;
    localparam int TICK_DIV   = 4;
    localparam int RISE_TICKS = 2;
    localparam int START_ROW  = 8;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        flap;
    logic [3:0]  bird_row;
    logic [15:0] bird_onehot;
    logic        crashed;
    logic        tick;

    bird_motion #(
        .ROWS      (ROWS),
        .TICK_DIV  (TICK_DIV),
        .RISE_TICKS(RISE_TICKS),
        .START_ROW (START_ROW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .flap       (flap),
        .bird_row   (bird_row),
        .bird_onehot(bird_onehot),
        .crashed    (crashed),
        .tick       (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Behavioural model: tracks whole-game quantities, advanced once per clock.
    int m_row;
    bit m_run;
    bit m_dead;
    int m_phase;
    int m_lift;
    bit m_tick;

    task automatic model_reset();
        m_row = START_ROW; m_run = 0; m_dead = 0; m_phase = 0; m_lift = 0; m_tick = 0;
    endtask

    task automatic model_step(input bit en, input bit fl);
        m_tick = 0;
        if (!en) begin
            model_reset();
        end else if (m_dead) begin
            m_phase = 0;
        end else if (!m_run) begin
            m_run = 1; m_phase = 0;
        end else if (fl) begin
            m_lift = RISE_TICKS; m_phase = 0;
        end else begin
            m_phase++;
            if (m_phase == TICK_DIV) begin
                m_phase = 0;
                m_tick  = 1;
                if (m_lift > 0) begin
`ifdef BIRD_CEILING_CRASH_EN
                    if (m_row == ROWS - 1) begin
                        m_dead = 1; m_run = 0; m_lift = 0;
                    end else begin
                        m_row++; m_lift--;
                    end
`else
                    if (m_row < ROWS - 1) m_row++;
                    m_lift--;
`endif
                end else if (m_row == 0) begin
                    m_dead = 1; m_run = 0;
                end else begin
                    m_row--;
                end
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_reset();
            else model_step(enable, flap);
            if (chk_en && !reset) begin
                #1;
                check("rnd_row",     32'(bird_row),    32'(m_row));
                check("rnd_onehot",  32'(bird_onehot), 32'(16'h1 << m_row));
                check("rnd_crashed", 32'(crashed),     32'(m_dead));
                check("rnd_tick",    32'(tick),        32'(m_tick));
            end
        end
    end

    typedef struct {
        bit    en;
        bit    fl;
        int    n;
        int    row;
        bit    crash;
        bit    tk;
        string name;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit en, input bit fl, input int n, input int row,
                       input bit crash, input bit tk, input string name);
        vec_t v;
        v.en = en; v.fl = fl; v.n = n; v.row = row; v.crash = crash; v.tk = tk; v.name = name;
        vecs.push_back(v);
    endtask

    // Drive one record: flap only on the first edge, enable held for n edges, check after the last.
    task automatic run_vec(input vec_t v);
        logic [15:0] exp_oh;
        @(negedge clk);
        enable = v.en;
        flap   = v.fl;
        for (int i = 0; i < v.n; i++) begin
            @(posedge clk);
            #1;
            flap = 1'b0;
        end
        exp_oh = 16'h1 << v.row;
        check({v.name, "_row"},     32'(bird_row),    32'(v.row));
        check({v.name, "_onehot"},  32'(bird_onehot), 32'(exp_oh));
        check({v.name, "_crashed"}, 32'(crashed),     32'(v.crash));
        check({v.name, "_tick"},    32'(tick),        32'(v.tk));
    endtask

    initial begin
        int rate;
        reset  = 1'b0;
        enable = 1'b0;
        flap   = 1'b0;

        add(1, 0, 1, 8, 0, 0, "idle_to_fall");
        add(1, 0, 3, 8, 0, 0, "count_up");
        add(1, 0, 1, 7, 0, 1, "first_tick");
        for (int r = 6; r >= 0; r--) add(1, 0, 4, r, 0, 1, "fall");
        add(1, 0, 4, 0, 1, 1, "floor_crash");
        add(1, 1, 1, 0, 1, 0, "crash_flap_ignored");
        add(1, 0, 8, 0, 1, 0, "crash_frozen");
        add(0, 0, 1, 8, 0, 0, "disable");
        add(1, 0, 1, 8, 0, 0, "reenable");
        for (int r = 7; r >= 5; r--) add(1, 0, 4, r, 0, 1, "fall");
        add(1, 1, 1, 5, 0, 0, "flap_at5");
        add(1, 0, 3, 5, 0, 0, "rise_wait");
        add(1, 0, 1, 6, 0, 1, "rise1");
        add(1, 0, 4, 7, 0, 1, "rise2");
        add(1, 0, 4, 6, 0, 1, "back_to_fall");
        for (int r = 7; r <= 11; r++) add(1, 1, 5, r, 0, 1, "flap_climb");
        add(1, 0, 3, 11, 0, 0, "rise_hold");
        add(0, 1, 1, 8, 0, 0, "disable_beats_flap_tick");
        add(1, 1, 1, 8, 0, 0, "idle_flap_ignored");
        add(1, 0, 4, 7, 0, 1, "fall_from_start");
        for (int r = 6; r >= 4; r--) add(1, 0, 4, r, 0, 1, "fall");
        add(1, 0, 3, 4, 0, 0, "pre_tick");
        add(1, 1, 1, 4, 0, 0, "flap_beats_tick");
        add(1, 0, 3, 4, 0, 0, "no_early_move");
        add(1, 0, 1, 5, 0, 1, "rise_after_clear");
        add(1, 0, 4, 6, 0, 1, "rise_second");
        add(1, 0, 4, 5, 0, 1, "fall_after_reload");
        for (int r = 6; r <= 15; r++) add(1, 1, 5, r, 0, 1, "flap_climb");
`ifdef BIRD_CEILING_CRASH_EN
        add(1, 1, 5, 15, 1, 1, "ceiling_crash");
        add(1, 0, 4, 15, 1, 0, "ceiling_frozen");
`else
        add(1, 1, 5, 15, 0, 1, "ceiling_sat1");
        add(1, 0, 4, 15, 0, 1, "ceiling_sat2");
        add(1, 0, 4, 14, 0, 1, "ceiling_fall");
`endif
        add(0, 0, 1, 8, 0, 0, "final_disable");

        // Reset state, including the asynchronous response before any clock edge.
        #2 reset = 1'b1;
        #1;
        check("async_reset_row", 32'(bird_row), 32'(START_ROW));
        repeat (5) @(posedge clk);
        #1;
        check("reset_row",     32'(bird_row),    32'(START_ROW));
        check("reset_onehot",  32'(bird_onehot), 32'h0100);
        check("reset_crashed", 32'(crashed),     32'(0));
        check("reset_tick",    32'(tick),        32'(0));
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Randomized play with a varying flap rate, checked every cycle against the model.
        @(negedge clk);
        chk_en = 1'b1;
        for (int blk = 0; blk < 15; blk++) begin
            rate = (blk % 3 == 0) ? 6 : ((blk % 3 == 1) ? 12 : 30);
            for (int c = 0; c < 200; c++) begin
                @(negedge clk);
                enable = ($urandom_range(0, 199) != 0);
                flap   = ($urandom_range(0, rate - 1) == 0);
            end
        end
        @(negedge clk);
        chk_en = 1'b0;
        enable = 1'b0;
        flap   = 1'b0;

        // Reset asserted mid-game must restore the start row without a clock edge.
        @(negedge clk);
        enable = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("pre_reset_row", 32'(bird_row), 32'(START_ROW - 1));
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("midop_reset_row",    32'(bird_row),    32'(START_ROW));
        check("midop_reset_onehot", 32'(bird_onehot), 32'h0100);
        check("midop_reset_tick",   32'(tick),        32'(0));
        @(negedge clk);
        reset  = 1'b0;
        enable = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
